dram_rd_arbiter: RTL

- Shares the single DRAM AXI4 read channel among three requesters: 0 = hash table, 1 = value store, 2 = buddy allocator.
- Accepts AR requests with round-robin arbitration and tags each with its requester index in ARID.
- Routes R beats back by RID.
- Caps outstanding bursts per requester so a slow consumer cannot starve the others.
- Sits in the mem_clk domain, directly in front of the memory controller read port.

---
 rtl/dram_rd_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dram_rd_arbiter.sv
// Three-way AXI4 read-channel arbiter in front of the DRAM controller: round-robin AR grant,
// RID-based R routing, per-requester outstanding-burst cap. Option: DRAM_RD_ARB_BUDDY_PRIO_EN.
module dram_rd_arbiter #(
  parameter int ADDR_WID  = 32,
  parameter int DATA_WID  = 512,
  parameter int ID_WID    = 5,
  parameter int MAX_OUTST = 4
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst,
  input  logic [3*ADDR_WID-1:0] s_araddr,
  input  logic [3*8-1:0]        s_arlen,
  input  logic [3*3-1:0]        s_arsize,
  input  logic [3*2-1:0]        s_arburst,
  input  logic [2:0]            s_arvalid,
  output logic [2:0]            s_arready,
  output logic [DATA_WID-1:0]   s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [2:0]            s_rvalid,
  input  logic [2:0]            s_rready,
  output logic [ADDR_WID-1:0]   m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [ID_WID-1:0]     m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WID-1:0]   m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic [ID_WID-1:0]     m_rid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  err_bad_rid
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and payload is held stable while valid is high.

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t          state;
  logic [1:0]      ptr;
  logic [3:0]      cnt [3];
  logic [2:0]      elig;
  logic [1:0]      grant;
  logic            grant_vld;
  logic [1:0]      next_ptr;
  logic [ADDR_WID-1:0] sel_addr;
  logic [7:0]      sel_len;
  logic [2:0]      sel_size;
  logic [1:0]      sel_burst;
  logic [1:0]      rsel;
  logic            ar_hs;
  logic            r_done;
  logic            unused_rid_hi;

  assign rsel          = m_rid[1:0];
  assign unused_rid_hi = ^m_rid;
  assign ar_hs         = m_arvalid && m_arready;
  assign r_done        = m_rvalid && m_rready && m_rlast;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    logic [2:0] s;
    s = {1'b0, p} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) elig[i] = s_arvalid[i] && (cnt[i] < MAX_CNT);
  end

  always_comb begin
    logic [1:0] cand;
    grant     = 2'd0;
    grant_vld = 1'b0;
    next_ptr  = ptr;
    cand      = 2'd0;
`ifdef DRAM_RD_ARB_BUDDY_PRIO_EN
    // Buddy wins outright; 0/1 share a one-bit pointer that buddy grants leave alone.
    if (elig[2]) begin
      grant     = 2'd2;
      grant_vld = 1'b1;
    end else if (elig[ptr[0]]) begin
      grant     = {1'b0, ptr[0]};
      grant_vld = 1'b1;
      next_ptr  = {1'b0, ~ptr[0]};
    end else if (elig[~ptr[0]]) begin
      grant     = {1'b0, ~ptr[0]};
      grant_vld = 1'b1;
      next_ptr  = {1'b0, ptr[0]};
    end
`else
    // Scan backwards so the candidate closest to ptr is the one that sticks.
    for (int k = 2; k >= 0; k--) begin
      cand = rr_idx(ptr, k);
      if (elig[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
    next_ptr = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
`endif
    if (state != IDLE || mem_rst) grant_vld = 1'b0;
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < 3; i++) begin
      s_arready[i] = grant_vld && (grant == 2'(i));
      if (grant == 2'(i)) begin
        sel_addr  = s_araddr[i*ADDR_WID +: ADDR_WID];
        sel_len   = s_arlen[i*8 +: 8];
        sel_size  = s_arsize[i*3 +: 3];
        sel_burst = s_arburst[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            m_araddr  <= sel_addr;
            m_arlen   <= sel_len;
            m_arsize  <= sel_size;
            m_arburst <= sel_burst;
            m_arid    <= ID_WID'(grant);
            m_arvalid <= 1'b1;
            ptr       <= next_ptr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counter tracks bursts from DRAM acceptance to their last beat; a decrement at zero is dropped.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic inc;
        logic dec;
        inc = ar_hs && (m_arid[1:0] == 2'(i));
        dec = r_done && (rsel == 2'(i)) && (cnt[i] != 4'd0);
        if (inc && !dec)      cnt[i] <= cnt[i] + 4'd1;
        else if (dec && !inc) cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst)                           err_bad_rid <= 1'b0;
    else if (m_rvalid && rsel == 2'd3)     err_bad_rid <= 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) s_rvalid[i] = m_rvalid && (rsel == 2'(i));
    case (rsel)
      2'd0:    m_rready = s_rready[0];
      2'd1:    m_rready = s_rready[1];
      2'd2:    m_rready = s_rready[2];
      default: m_rready = 1'b1;
    endcase
  end

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

endmodule
